// File: rtl/vm_change_pkg.sv
// Shared types and defaults for the change dispenser.
// State encoding, coin values and the stock level loaded at reset/refill.
package vm_change_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAY   = 2'd1,
    FAULT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int COIN_HI_VAL   = 5;
  localparam int COIN_LO_VAL   = 1;
  localparam int STOCK_MAX_DEF = 20;

endpackage

// File: rtl/vend_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect; o_rise is one clk_1Hz period wide.
// Latency: o_rise is seen by logic on the 3rd clock edge after i_async rises; no backpressure.
module vend_edge_sync (
  input  logic clk_1Hz,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin per clk_1Hz period, largest coin first, tracking tube stock and alarming when stuck.
// Optional CHANGE_AUDIT_EN adds the paid_total running sum of ejected coin value.
module change_dispenser
  import vm_change_pkg::*;
#(
  parameter int CHG_W     = 4,
  parameter int COIN_HI   = COIN_HI_VAL,
  parameter int STOCK_W   = 6,
  parameter int STOCK_MAX = STOCK_MAX_DEF
) (
  input  logic               clk_1Hz,
  input  logic               rst_n,
  input  logic               vend_done,
  input  logic [CHG_W-1:0]   change_in,
  input  logic               refill,
  output logic               coin_hi,
  output logic               coin_lo,
  output logic               busy,
  output logic               done,
  output logic               alarm,
  output logic               overrun,
  output logic [CHG_W-1:0]   remaining,
  output logic [STOCK_W-1:0] stock_hi,
  output logic [STOCK_W-1:0] stock_lo
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [7:0]         paid_total
`endif
);

  localparam logic [CHG_W-1:0]   W_COIN_HI   = CHG_W'(COIN_HI);
  localparam logic [CHG_W-1:0]   W_ONE_C     = CHG_W'(COIN_LO_VAL);
  localparam logic [STOCK_W-1:0] W_ONE_S     = STOCK_W'(1);
  localparam logic [STOCK_W-1:0] W_STOCK_MAX = STOCK_W'(STOCK_MAX);

  state_t             r_state;
  logic               r_coin_hi;
  logic               r_coin_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_alarm;
  logic               r_overrun;
  logic [CHG_W-1:0]   r_remaining;
  logic [STOCK_W-1:0] r_stock_hi;
  logic [STOCK_W-1:0] r_stock_lo;

  logic w_start;
  logic w_take_hi;
  logic w_take_lo;

  vend_edge_sync u_vend_sync (
    .clk_1Hz (clk_1Hz),
    .rst_n   (rst_n),
    .i_async (vend_done),
    .o_rise  (w_start)
  );

  // Large coin only falls back to small coins when its tube is empty.
  assign w_take_hi = (r_state == PAY) && (r_remaining >= W_COIN_HI) && (r_stock_hi != '0);
  assign w_take_lo = (r_state == PAY) && !w_take_hi && (r_stock_lo != '0);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_coin_hi   <= 1'b0;
      r_coin_lo   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_overrun   <= 1'b0;
      r_remaining <= '0;
      r_stock_hi  <= W_STOCK_MAX;
      r_stock_lo  <= W_STOCK_MAX;
    end else begin
      r_coin_hi <= 1'b0;
      r_coin_lo <= 1'b0;
      r_done    <= 1'b0;

      if (w_start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (change_in != '0) begin
              r_remaining <= change_in;
              r_busy      <= 1'b1;
              r_state     <= PAY;
            end else begin
              r_state <= DONE;
            end
          end
        end
        PAY: begin
          if (w_take_hi) begin
            r_coin_hi   <= 1'b1;
            r_remaining <= r_remaining - W_COIN_HI;
            r_stock_hi  <= r_stock_hi - W_ONE_S;
            if (r_remaining == W_COIN_HI) begin
              r_busy  <= 1'b0;
              r_state <= DONE;
            end
          end else if (w_take_lo) begin
            r_coin_lo   <= 1'b1;
            r_remaining <= r_remaining - W_ONE_C;
            r_stock_lo  <= r_stock_lo - W_ONE_S;
            if (r_remaining == W_ONE_C) begin
              r_busy  <= 1'b0;
              r_state <= DONE;
            end
          end else begin
            r_alarm <= 1'b1;
            r_state <= FAULT;
          end
        end
        FAULT: begin
          if (refill) begin
            r_alarm <= 1'b0;
            r_state <= PAY;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Refill wins over any same-edge decrement.
      if (refill) begin
        r_stock_hi <= W_STOCK_MAX;
        r_stock_lo <= W_STOCK_MAX;
      end
    end
  end

  assign coin_hi   = r_coin_hi;
  assign coin_lo   = r_coin_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign alarm     = r_alarm;
  assign overrun   = r_overrun;
  assign remaining = r_remaining;
  assign stock_hi  = r_stock_hi;
  assign stock_lo  = r_stock_lo;

`ifdef CHANGE_AUDIT_EN
  localparam logic [7:0] W_PAID_HI = 8'(COIN_HI);
  localparam logic [7:0] W_PAID_LO = 8'(COIN_LO_VAL);

  logic [7:0] r_paid_total;

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_paid_total <= 8'd0;
    end else if (w_take_hi) begin
      r_paid_total <= r_paid_total + W_PAID_HI;
    end else if (w_take_lo) begin
      r_paid_total <= r_paid_total + W_PAID_LO;
    end
  end

  assign paid_total = r_paid_total;
`endif

endmodule
